// File: rtl/fpu_div_pkg.sv
// Shared types and sizing helpers for the FPU mantissa divide path.
package fpu_div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } div_state_t;

    localparam int unsigned DefWidth = 24;

    // Quotient width: integer bit, fraction bits, guard and round.
    function automatic int unsigned calc_qw(input int unsigned width);
        return width + 2;
    endfunction

endpackage

// File: rtl/div_pe_row.sv
// One row of subtract/select PE cells: diff = a - b, res = sel ? diff : a.
module div_pe_row #(
    parameter int unsigned W = 25
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel,
    output logic [W-1:0] res,
    output logic         cout
);

    logic [W-1:0] diff;
    logic [W:0]   carry;

    // Ripple chain of full-adder subtractors; carry-in of the LSB cell is 1.
    always_comb begin
        carry    = '0;
        diff     = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < int'(W); i++) begin
            diff[i]      = a[i] ^ ~b[i] ^ carry[i];
            carry[i + 1] = (a[i] & ~b[i]) | (carry[i] & (a[i] ^ ~b[i]));
        end
    end

    assign cout = carry[W];
    assign res  = sel ? diff : a;

endmodule

// File: rtl/mant_div_seq.sv
// Sequential restoring mantissa divider: one quotient bit per cycle through a shared PE row.
module mant_div_seq
    import fpu_div_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned QW    = calc_qw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QW-1:0]    quotient,
    output logic             sticky,
    output logic             dbz,
    output logic             busy
);

    localparam int unsigned RW   = WIDTH + 1;
    localparam int unsigned CntW = $clog2(QW);

    div_state_t      state_q;
    logic [RW-1:0]   r_q;
    logic [RW-1:0]   d_q;
    logic [CntW-1:0] cnt_q;
    logic [QW-1:0]   quot_q;
    logic            sticky_q;
    logic            dbz_q;

    logic [RW-1:0]   rem;
    logic            q_bit;

    div_pe_row #(
        .W (RW)
    ) u_pe_row (
        .a    (r_q),
        .b    (d_q),
        .sel  (q_bit),
        .res  (rem),
        .cout (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            r_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            quot_q   <= '0;
            sticky_q <= 1'b0;
            dbz_q    <= 1'b0;
        end else if (flush) begin
            state_q <= StIdle;
            dbz_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        if (divisor != '0) begin
                            r_q     <= {1'b0, dividend};
                            d_q     <= {1'b0, divisor};
                            cnt_q   <= '0;
                            quot_q  <= '0;
                            state_q <= StCalc;
                        end else begin
                            quot_q   <= '1;
                            sticky_q <= 1'b0;
                            dbz_q    <= 1'b1;
                            state_q  <= StDone;
                        end
                    end
                end
                StCalc: begin
                    quot_q <= {quot_q[QW-2:0], q_bit};
                    // rem < D always, so dropping its MSB on the shift loses nothing.
                    r_q    <= {rem[RW-2:0], 1'b0};
                    if (cnt_q == CntW'(QW - 1)) begin
                        sticky_q <= |rem;
                        state_q  <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                        dbz_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StCalc);
    assign quotient  = quot_q;
    assign sticky    = sticky_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_mant_div_seq.sv
// Self-checking bench for mant_div_seq at WIDTH=4 with a result scoreboard.
module tb_mant_div_seq;

    localparam int unsigned W  = 4;
    localparam int unsigned QW = W + 2;

    typedef struct packed {
        logic [QW-1:0] quot;
        logic          sticky;
        logic          dbz;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] quotient;
    logic          sticky;
    logic          dbz;
    logic          busy;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    mant_div_seq #(
        .WIDTH (W),
        .QW    (QW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .sticky    (sticky),
        .dbz       (dbz),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: quotient = floor(dd * 2^(QW-1) / dv), sticky = remainder nonzero.
    function automatic exp_t model(input logic [W-1:0] dd, input logic [W-1:0] dv);
        exp_t e;
        int unsigned num;
        if (dv == '0) begin
            e.quot   = '1;
            e.sticky = 1'b0;
            e.dbz    = 1'b1;
        end else begin
            num      = int'(dd) << (QW - 1);
            e.quot   = QW'(num / int'(dv));
            e.sticky = (num % int'(dv)) != 0;
            e.dbz    = 1'b0;
        end
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_quotient"}, 32'(quotient), 32'd0);
        check({tag, "_sticky"}, 32'(sticky), 32'd0);
        check({tag, "_dbz"}, 32'(dbz), 32'd0);
    endtask

    task automatic accept(input logic [W-1:0] dd, input logic [W-1:0] dv);
        int n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        sb.push_back(model(dd, dv));
        step();
        in_valid = 1'b0;
        dividend = ~dd;
        divisor  = ~dv;
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int   lat = 1;
        exp_t e;
        while (!out_valid && lat < 50) begin
            check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_quotient"}, 32'(quotient), 32'(e.quot));
            check({tag, "_sticky"}, 32'(sticky), 32'(e.sticky));
            check({tag, "_dbz"}, 32'(dbz), 32'(e.dbz));
            check({tag, "_done_ready"}, 32'(in_ready), 32'd0);
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        check("retire_ready_low", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] dd_tab[3];
        logic [W-1:0] dv_tab[3];
        logic [QW-1:0] held_q;
        logic         held_s;
        dd_tab = '{4'b1000, 4'b1100, 4'b1000};
        dv_tab = '{4'b1000, 4'b1000, 4'b1100};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        step();
        step();
        rst = 1'b0;
        check_reset_outputs("reset");

        for (int i = 0; i < 3; i++) begin
            accept(dd_tab[i], dv_tab[i]);
            wait_result("table", QW + 1);
            retire();
        end

        for (int i = 0; i < 6; i++) begin
            accept(W'($urandom_range(8, 15)), W'($urandom_range(8, 15)));
            wait_result("rand", QW + 1);
            retire();
        end

        accept(4'b1011, 4'b0000);
        wait_result("dbz", 1);
        retire();
        check("dbz_cleared", 32'(dbz), 32'd0);
        check("dbz_in_ready", 32'(in_ready), 32'd1);

        // Abort at cnt = 3, then start a fresh operation one cycle later.
        accept(4'b1101, 4'b1001);
        step();
        step();
        step();
        check("flush_busy_before", 32'(busy), 32'd1);
        flush    = 1'b1;
        in_valid = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        void'(sb.pop_front());
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        accept(4'b1111, 4'b1010);
        wait_result("post_flush", QW + 1);
        retire();

        // Stall in DONE with new operands offered.
        accept(4'b1001, 4'b1110);
        wait_result("stall", QW + 1);
        held_q   = quotient;
        held_s   = sticky;
        in_valid = 1'b1;
        dividend = 4'b1111;
        divisor  = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_ready", 32'(in_ready), 32'd0);
            check("stall_quot", 32'(quotient), 32'(held_q));
            check("stall_sticky", 32'(sticky), 32'(held_s));
        end
        in_valid = 1'b0;
        retire();
        check("stall_idle", 32'(in_ready), 32'd1);

        // Reset mid-operation.
        accept(4'b1010, 4'b1011);
        step();
        step();
        check("rst_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        check_reset_outputs("rst_calc");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mant_div_seq.md
# mant_div_seq

Sequential restoring-division controller for the FPU mantissa divider. It time-multiplexes a single row of subtract/select PE cells over `QW` cycles, one quotient bit per cycle, instead of instantiating a full `QW`-row array. It sits between the divide-path unpacker (normalized mantissas in) and the normalize/round stage (quotient plus sticky out).

## Interface
- `WIDTH`, 24: mantissa width including the hidden bit. Both operands are normalized, MSB = 1, except divisor = 0.
- `QW`, `WIDTH+2`: quotient bits produced. The MSB has weight 2^0; the last two bits are guard and round.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous abort of any operation in flight.
- `in_valid` in 1: operands valid.
- `in_ready` out 1: block can accept operands.
- `dividend` in `WIDTH`: normalized dividend mantissa.
- `divisor` in `WIDTH`: normalized divisor mantissa.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `quotient` out `QW`: quotient bits.
- `sticky` out 1: 1 if the final remainder is nonzero.
- `dbz` out 1: divide-by-zero flag.
- `busy` out 1: high in CALC state.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid` with divisor != 0: load R = {1'b0, dividend} (`WIDTH+1` bits), D = {1'b0, divisor}, cnt = 0, quotient = 0; go to CALC.
  - On `in_valid` with divisor == 0: quotient = all ones, sticky = 0, dbz = 1; go to DONE directly.
- CALC, one step per cycle:
  - diff = R + ~D + 1 via the PE row, carry-in of the LSB cell = 1.
  - q = carry-out of the MSB cell; carry-out = 1 means no borrow.
  - Row select = q, so rem = q ? diff : R.
  - quotient ← {quotient[QW-2:0], q}; R ← rem << 1, with a 0 shifted into the LSB; cnt increments.
  - On the step where cnt = QW-1: sticky ← |rem, taken pre-shift. Go to DONE.
- DONE:
  - `out_valid` = 1; `quotient`, `sticky` and `dbz` are held stable.
  - On `out_ready`: go to IDLE and clear dbz.
- Arithmetic:
  - Operands lie in [1,2), so the quotient lies in (0.5,2).
  - R < 2D always holds, so `WIDTH+1` bits suffice and no overflow can occur.
- cnt width is clog2(QW). cnt never wraps; it is reset on every load.
- `flush` in any state: go to IDLE, `out_valid` = 0, dbz = 0, nothing accepted in that cycle. `flush` takes priority over `in_valid` and `out_ready`.
- `rst` has the same effect as `flush`, plus it clears quotient, sticky, R, D and cnt.

## Timing
- Reset values:
  - state = IDLE.
  - `in_ready` = 1 (decoded from state).
  - `out_valid` = 0, `busy` = 0.
  - `quotient` = 0, `sticky` = 0, `dbz` = 0.
- `in_ready`, `out_valid` and `busy` are pure decodes of the state register; there is no combinational path from inputs to outputs.
- Normal latency:
  - Accept at edge T0.
  - CALC occupies cycles T0+1 … T0+QW.
  - `out_valid` rises in cycle T0+QW+1.
  - Default configuration: 27 cycles from accept to `out_valid`.
- Divide-by-zero latency: `out_valid` in cycle T0+1.
- Throughput: one operation per QW+2 cycles minimum. `in_ready` is 0 in CALC and DONE, including the cycle in which `out_ready` is taken.
- Output stall: DONE holds indefinitely while `out_ready` = 0, with outputs unchanged.
- Operand changes on `dividend`/`divisor` after the accept edge have no effect.

## Structure
- Shared package `fpu_div_pkg` holds:
  - state enum `div_state_t` (IDLE, CALC, DONE);
  - localparam for the default `WIDTH`;
  - function computing QW from WIDTH.
- One sub-module, `div_pe_row`:
  - `WIDTH+1` instances of the existing PE cell (full-adder subtractor plus select mux), ripple-chained;
  - shared `sel` input, exported MSB carry-out.
- The controller itself contains only the state register, R, D, cnt and the quotient shift register.

## Test plan
- WIDTH=4, dividend 1000, divisor 1000 → `out_valid` at accept+7, quotient 100000, sticky 0, dbz 0.
- WIDTH=4, dividend 1100, divisor 1000 → quotient 110000, sticky 0.
- WIDTH=4, dividend 1000, divisor 1100 → quotient 010101, sticky 1.
- Divisor 0, any dividend → `out_valid` at accept+1, quotient all ones, dbz 1, sticky 0. After `out_ready`, dbz = 0 and `in_ready` = 1 in the next cycle.
- Assert `flush` mid-CALC (cnt = 3), then `in_valid` one cycle later → the aborted operation never produces `out_valid`; the new operation's result arrives at its own accept+QW+1.
- Hold `out_ready` low 10 cycles in DONE with `in_valid` = 1 → outputs stable, `in_ready` = 0 throughout. Additionally, assert `rst` during CALC → next cycle all outputs at reset values.
